// File: rtl/pc_pkg.sv
// Shared opcode and PC-source encodings for the PC sequencer and its return stack.
package pc_pkg;

   localparam logic [3:0] OP_BGT  = 4'b1000;
   localparam logic [3:0] OP_BLT  = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;
   localparam logic [3:0] OP_BNE  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_CALL = 4'b1101;
   localparam logic [3:0] OP_RET  = 4'b1110;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_JMP = 2'b01;
   localparam logic [1:0] PCSRC_BR  = 2'b10;
   localparam logic [1:0] PCSRC_RET = 2'b11;

   // Signed compares share flags, so the mode bit plays no part here.
   function automatic logic cond_taken(input logic [3:0] op, input logic zero,
                                       input logic negative, input logic overflow);
      logic taken;
      taken = 1'b0;
      case (op)
         OP_BGT:  taken = !zero && (negative == overflow);
         OP_BLT:  taken = negative != overflow;
         OP_BEQ:  taken = zero;
         OP_BNE:  taken = !zero;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address ring stack: pushes past full overwrite the oldest entry,
// pops while empty leave the pointer alone. Event outputs flag both cases.
module ras_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         ovf_evt_o,
   output logic         unf_evt_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] top_q, top_d, wr_ptr;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign wr_ptr    = top_q + PtrW'(1);
   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CntW'(DEPTH));
   assign top_o     = mem_q[top_q];
   assign ovf_evt_o = push_i & full_o;
   assign unf_evt_o = pop_i & empty_o;

   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (push_i) begin
         top_d = wr_ptr;
         if (!full_o) cnt_d = cnt_q + CntW'(1);
      end else if (pop_i && !empty_o) begin
         top_d = top_q - PtrW'(1);
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Top starts one below slot 0 so the first push lands at index 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         top_q <= PtrW'(DEPTH - 1);
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch condition decode, next-PC mux, PC register,
// hardware return stack for CALL/RET and sticky stack error flags.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned  PC_W        = 16,
   parameter int unsigned  INSTR_BYTES = 2,
   parameter int unsigned  RAS_DEPTH   = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            pc_we_i,
   input  logic [3:0]      op_i,
   input  logic            m_i,
   input  logic            branch_i,
   input  logic            zero_i,
   input  logic            negative_i,
   input  logic            carry_i,
   input  logic            overflow_i,
   input  logic [PC_W-1:0] branch_target_i,
   input  logic [PC_W-1:0] jump_target_i,
   input  logic            err_clr_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_next_o,
   output logic [1:0]      pc_src_o,
   output logic            ras_empty_o,
   output logic            ras_full_o,
   output logic            ras_ovf_o,
   output logic            ras_unf_o
);

   logic [PC_W-1:0] pc_q, pc_seq, ras_top;
   logic            taken, push, pop, ovf_evt, unf_evt;
   logic            ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;
   logic            unused_inputs;

   assign unused_inputs = m_i ^ carry_i;

   assign pc_seq = pc_q + PC_W'(INSTR_BYTES);
   assign taken  = branch_i && cond_taken(op_i, zero_i, negative_i, overflow_i);
   assign push   = pc_we_i && (op_i == OP_CALL);
   assign pop    = pc_we_i && (op_i == OP_RET);

   always_comb begin
      pc_src_o  = PCSRC_SEQ;
      pc_next_o = pc_seq;
      if (rst_i) begin
         pc_src_o  = PCSRC_SEQ;
      end else if (taken) begin
         pc_src_o  = PCSRC_BR;
         pc_next_o = branch_target_i;
      end else if ((op_i == OP_JMP) || (op_i == OP_CALL)) begin
         pc_src_o  = PCSRC_JMP;
         pc_next_o = jump_target_i;
      end else if ((op_i == OP_RET) && !ras_empty_o) begin
         pc_src_o  = PCSRC_RET;
         pc_next_o = ras_top;
      end
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push),
      .pop_i     (pop),
      .data_i    (pc_seq),
      .top_o     (ras_top),
      .empty_o   (ras_empty_o),
      .full_o    (ras_full_o),
      .ovf_evt_o (ovf_evt),
      .unf_evt_o (unf_evt)
   );

   // A new error event on the same edge as err_clr keeps the flag set.
   always_comb begin
      ras_ovf_d = err_clr_i ? 1'b0 : ras_ovf_q;
      ras_unf_d = err_clr_i ? 1'b0 : ras_unf_q;
      if (ovf_evt) ras_ovf_d = 1'b1;
      if (unf_evt) ras_unf_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q      <= RESET_PC;
         ras_ovf_q <= 1'b0;
         ras_unf_q <= 1'b0;
      end else begin
         if (pc_we_i) pc_q <= pc_next_o;
         ras_ovf_q <= ras_ovf_d;
         ras_unf_q <= ras_unf_d;
      end
   end

   assign pc_o      = pc_q;
   assign ras_ovf_o = ras_ovf_q;
   assign ras_unf_o = ras_unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the multicycle RISC core. It owns the PC register and resolves conditional branches, JMP, CALL and RET. It keeps a hardware return-address stack (RAS) so RET needs no memory access. It sits between the control FSM, which strobes PC updates, and the instruction-fetch address path. It supersedes the purely combinational PC-source decode, adding parametrised PC width, instruction size and stack depth.

## Interface
Parameters:
- PC_W, 16, PC and target width in bits
- INSTR_BYTES, 2, sequential increment (PC + INSTR_BYTES)
- RAS_DEPTH, 8, return-stack entries; power of two, ≥ 2
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears PC to RESET_PC, empties RAS, clears error flags
- pc_we  in  1  control-FSM strobe; PC and RAS update only on edges where pc_we=1
- op  in  4  instruction opcode
- m  in  1  mode bit; decoded but does not change branch condition (BGT/BGTZ etc. share flags)
- branch  in  1  branch-enable from control unit
- zero, negative, carry, overflow  in  1 each  ALU flags; carry unused, kept for flag bundle
- branch_target  in  PC_W  precomputed PC-relative target
- jump_target  in  PC_W  absolute JMP/CALL target
- err_clr  in  1  synchronous clear of sticky error flags
- pc  out  PC_W  current PC register
- pc_next  out  PC_W  combinational value PC will take on next pc_we
- pc_src  out  2  00 sequential, 01 jump/call, 10 branch taken, 11 return
- ras_empty  out  1  stack count = 0
- ras_full  out  1  stack count = RAS_DEPTH
- ras_ovf  out  1  sticky: CALL pushed while full
- ras_unf  out  1  sticky: RET popped while empty

## Operation
- Opcodes: 1000 BGT/BGTZ, 1001 BLT/BLTZ, 1010 BEQ/BEQZ, 1011 BNE/BNEZ, 1100 JMP, 1101 CALL, 1110 RET. Any other opcode is sequential.
- Taken conditions, all gated by branch=1:
  - BGT: !zero && (negative==overflow)
  - BLT: negative!=overflow
  - BEQ: zero
  - BNE: !zero
- pc_src and pc_next:
  - Taken branch: 10, branch_target.
  - JMP and CALL: 01, jump_target.
  - RET with stack non-empty: 11, top of stack.
  - RET with stack empty: 00, PC+INSTR_BYTES.
  - Otherwise: 00, PC+INSTR_BYTES.
- PC+INSTR_BYTES is computed modulo 2^PC_W; wrap from max to 0 is legal and silent.
- CALL with pc_we pushes PC+INSTR_BYTES.
  - If not full: push and increment count.
  - If full: the ring overwrites the oldest entry, count stays RAS_DEPTH, and ras_ovf sets.
- RET with pc_we pops when non-empty. When empty, the pointer is unchanged and ras_unf sets.
- Sticky flags are set or cleared on the edge. If set and err_clr occur on the same edge, set wins.
- With pc_we=0, no state changes regardless of op or flags.

## Timing
- pc_next, pc_src and the empty/full flags are combinational from inputs and state; there are no registered outputs other than pc and the sticky flags.
- PC update latency is one clock: pc equals pc_next on the edge where pc_we=1.
- Push and pop take effect on the same edge as the PC update. A RET immediately after a CALL returns the pushed address.
- While reset is asserted, outputs hold reset values: pc=RESET_PC, pc_src=00, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
- Reset asserted mid-sequence aborts any pending update. Stack contents are discarded and count goes to 0.
- First update is taken on the first edge after reset deasserts with pc_we=1.

## Structure
- pc_pkg holds:
  - opcode localparams OP_BGT, OP_BLT, OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_RET
  - PCSRC_SEQ, PCSRC_JMP, PCSRC_BR, PCSRC_RET encodings
- Sub-module ras_stack(DEPTH, W) implements:
  - ring buffer with top pointer and count
  - push and pop inputs, top data out
  - empty, full, ovf_evt and unf_evt outputs
- pc_sequencer holds the condition decode, next-PC mux, PC register and sticky flags.

## Test plan
- Reset with RESET_PC=16'h0100, then 3 pc_we pulses, op=0000 → pc = 0x0102, 0x0104, 0x0106; pc_src=00.
- BEQ (1010) with branch=1, zero=1, target 0x0200 → pc=0x0200, pc_src=10. Same with zero=0 → pc = PC+2. Same with branch=0 → not taken.
- BGT: negative=overflow=1, zero=0 → taken. negative=1, overflow=0 → not taken. BLT with negative=1, overflow=0 → taken. Repeat BGT and BLT with m toggled → identical results.
- CALL at 0x0010 to 0x0300, then RET with pc_we → pc=0x0300, then pc=0x0012, pc_src=11, ras_empty=1.
- 9 nested CALLs with RAS_DEPTH=8 → ras_full=1, ras_ovf=1. Then 8 RETs return the last 8 pushed addresses in LIFO order. A 9th RET → ras_unf=1, pc=PC+2. err_clr → both flags 0.
- Assert reset between a CALL and its RET → pc=RESET_PC, ras_empty=1. A subsequent RET sets ras_unf.
